if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch front end with a decoupling prefetch queue, successor to the single-register IF stage. It drives the instruction RAM read port, captures returned words with their PCs into a QDEPTH-entry FIFO, and presents the queue head to the ID stage with a valid flag. ID back-pressure and I-cache stalls therefore no longer need roll/collision registers. It also handles redirects (trap over jump/return), flushes and monitor read access.

## Interface
Parameters:
- IWIDTH, 14, log2 of instruction RAM depth in words; RAM address is [IWIDTH+1:2]
- QDEPTH, 4, queue entries; power of two, 2..16
- NOP, 32'h0000_0013, instruction word presented when the queue is empty

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_start  in  1  start pulse; loads start_adr and enables fetching
- start_adr  in  [31:2]  start PC
- trap_cond  in  1  ecall/interrupt/exception redirect
- trap_adr  in  [31:2]  trap vector (mtvec)
- jmp_cond  in  1  branch/jump/xret redirect
- jmp_adr  in  [31:2]  jump target
- ic_stall  in  1  I-cache miss; RAM word for this cycle's address is invalid
- id_stall  in  1  ID cannot accept an instruction this cycle
- i_read_sel  in  1  monitor owns the RAM read port
- mon_radr  in  [IWIDTH+1:2]  monitor read address
- ram_radr  out  [IWIDTH+1:2]  RAM read address
- ram_rdata  in  32  RAM read data, valid one cycle after ram_radr
- mon_rdata  out  32  equals ram_rdata
- pc_if  out  [31:2]  next fetch PC
- inst_id  out  32  queue-head instruction, or NOP when empty
- pc_id  out  [31:2]  queue-head PC, or 0 when empty
- valid_id  out  1  queue non-empty
- q_count  out  $clog2(QDEPTH)+1  entries held

## Operation
- run flag: cleared by reset; set by pc_start; never cleared except by reset.
- flush = pc_start | trap_cond | (jmp_cond & ~post_trap). post_trap is trap_cond registered one cycle, so a jump arriving the cycle after a trap is ignored.
- Redirect target priority: pc_start > trap > jump.
- issue = run & ~flush & ~ic_stall & ~i_read_sel & (q_count + inflight < QDEPTH). This check is conservative: a same-cycle pop does not create room.
- On issue, ram_radr = pc_if[IWIDTH+1:2]; pc_if increments by 1 with 30-bit wrap. inflight <= 1 and the issued PC is latched. With no issue, inflight <= 0.
- ram_radr = mon_radr when i_read_sel is set, otherwise pc_if[IWIDTH+1:2].
- Return cycle: if inflight & ~flush, {latched PC, ram_rdata} is written at the tail.
- pop = valid_id & ~id_stall & ~flush; head pointer advances.
- Simultaneous push and pop leave q_count unchanged. Push never occurs when full, by construction; a push when full is an assertion failure.
- flush: head = tail = 0, q_count = 0, inflight = 0; pc_if <= redirect target. The in-flight word is discarded even if its RAM data arrives that cycle.
- Pointers are $clog2(QDEPTH) bits wide and wrap modulo QDEPTH.

## Timing
- Reset values: pc_if 0, ram_radr 0, inst_id NOP, pc_id 0, valid_id 0, q_count 0, mon_rdata = ram_rdata, run 0, inflight 0, post_trap 0.
- pc_start high in cycle N: pc_if = start_adr in N+1 and first issue in N+1. Data is pushed at the end of N+2; valid_id = 1 with the first instruction in N+3.
- Redirect in cycle N: outputs are empty (NOP, valid 0) from N+1. Target is issued in N+1 and visible at ID in N+3. Redirect-to-ID penalty is 3 cycles.
- Steady state with no stalls: one issue, one push and one pop per cycle. q_count holds at 1.
- id_stall holding: the queue fills to QDEPTH, then issue stops. Release restarts issue in the same cycle that q_count + inflight < QDEPTH becomes true.
- ic_stall: no issue while asserted. The queue keeps draining to ID; ID sees no NOP unless the queue empties.
- Reset asserted mid-operation clears everything asynchronously. Fetching stays halted until the next pc_start.

## Test plan
- Reset, then pc_start with start_adr = 0x40: pc_id 0x40, 0x41, 0x42 appear on consecutive cycles from N+3, valid_id continuous, q_count = 1.
- id_stall held 10 cycles in steady state: q_count saturates at 4, ram_radr holds. After release, 4 queued instructions and then new ones appear in order with no gaps or duplicates.
- jmp_cond with jmp_adr = 0x100 while 3 entries are queued: next cycle valid_id = 0, q_count = 0; pc_id = 0x100 three cycles after the jump.
- trap_cond with trap_adr = 0x200, then jmp_cond to 0x300 in the next cycle: the fetch stream resumes at 0x200 and 0x300 is never fetched. With trap and jump in the same cycle, 0x200 is taken.
- ic_stall for 5 cycles with 2 entries queued: both entries are consumed, then NOP/valid 0 is presented; fetch resumes at the stalled PC with no skipped PC.
- i_read_sel = 1 with mon_radr = 0x10: mon_rdata equals RAM word 0x10 one cycle later, no issue occurs and pc_if is unchanged.

Source files
------------

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: issues RAM reads ahead of ID and buffers the
// returned {PC, word} pairs in a small FIFO so ID stalls never stall the RAM.
module if_fetch_queue #(
  parameter int          IWIDTH = 14,
  parameter int          QDEPTH = 4,
  parameter logic [31:0] NOP    = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pc_start,
  input  logic [31:2]              start_adr,
  input  logic                     trap_cond,
  input  logic [31:2]              trap_adr,
  input  logic                     jmp_cond,
  input  logic [31:2]              jmp_adr,
  input  logic                     ic_stall,
  input  logic                     id_stall,
  input  logic                     i_read_sel,
  input  logic [IWIDTH+1:2]        mon_radr,
  output logic [IWIDTH+1:2]        ram_radr,
  input  logic [31:0]              ram_rdata,
  output logic [31:0]              mon_rdata,
  output logic [31:2]              pc_if,
  output logic [31:0]              inst_id,
  output logic [31:2]              pc_id,
  output logic                     valid_id,
  output logic [$clog2(QDEPTH):0]  q_count
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] QFULL = (CW+1)'(QDEPTH);

  typedef struct packed {
    logic [31:2] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t        q [QDEPTH];
  logic [PW-1:0] head, tail;
  logic          run, inflight, post_trap;
  logic [31:2]   pc_inflight, target;
  logic          flush, issue, push, pop;
  logic [CW:0]   occ;

  // A jump in the cycle right after a trap is the trapped instruction's own
  // redirect and must not override the trap vector.
  assign flush = pc_start | trap_cond | (jmp_cond & ~post_trap);

  always_comb begin
    target = jmp_adr;
    if (pc_start)       target = start_adr;
    else if (trap_cond) target = trap_adr;
  end

  // Queue entries plus the word still in the RAM pipe; a same-cycle pop is
  // deliberately not credited.
  assign occ   = {1'b0, q_count} + {{CW{1'b0}}, inflight};
  assign issue = run & ~flush & ~ic_stall & ~i_read_sel & (occ < QFULL);
  assign push  = inflight & ~flush;
  assign pop   = valid_id & ~id_stall & ~flush;

  assign ram_radr  = i_read_sel ? mon_radr : pc_if[IWIDTH+1:2];
  assign mon_rdata = ram_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      post_trap   <= 1'b0;
      inflight    <= 1'b0;
      pc_inflight <= '0;
      pc_if       <= '0;
      head        <= '0;
      tail        <= '0;
      q_count     <= '0;
    end else begin
      post_trap <= trap_cond;
      if (pc_start) run <= 1'b1;
      inflight <= issue;
      if (issue) pc_inflight <= pc_if;
      if (flush) begin
        head    <= '0;
        tail    <= '0;
        q_count <= '0;
        pc_if   <= target;
      end else begin
        if (issue) pc_if <= pc_if + 30'd1;
        if (push)  tail  <= tail + 1'b1;
        if (pop)   head  <= head + 1'b1;
        case ({push, pop})
          2'b10:   q_count <= q_count + 1'b1;
          2'b01:   q_count <= q_count - 1'b1;
          default: q_count <= q_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= '{pc: pc_inflight, inst: ram_rdata};
  end

  assign valid_id = (q_count != '0);
  assign inst_id  = valid_id ? q[head].inst : NOP;
  assign pc_id    = valid_id ? q[head].pc   : '0;

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && ({1'b0, q_count} == QFULL)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency RAM whose word
// at address a is 0xC000_0000 | a.
module tb_if_fetch_queue;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst_n;
  logic        pc_start, trap_cond, jmp_cond, ic_stall, id_stall, i_read_sel;
  logic [31:2] start_adr, trap_adr, jmp_adr, pc_if, pc_id;
  logic [15:2] mon_radr, ram_radr;
  logic [31:0] ram_rdata, mon_rdata, inst_id;
  logic        valid_id;
  logic [2:0]  q_count;

  int n_chk = 0;
  int n_fail = 0;

  if_fetch_queue dut (
    .clk(clk), .rst_n(rst_n), .pc_start(pc_start), .start_adr(start_adr),
    .trap_cond(trap_cond), .trap_adr(trap_adr), .jmp_cond(jmp_cond), .jmp_adr(jmp_adr),
    .ic_stall(ic_stall), .id_stall(id_stall), .i_read_sel(i_read_sel), .mon_radr(mon_radr),
    .ram_radr(ram_radr), .ram_rdata(ram_rdata), .mon_rdata(mon_rdata), .pc_if(pc_if),
    .inst_id(inst_id), .pc_id(pc_id), .valid_id(valid_id), .q_count(q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) ram_rdata <= 32'hC000_0000 | {18'd0, ram_radr};

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hC000_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; pc_start = 0; trap_cond = 0; jmp_cond = 0; ic_stall = 0;
    id_stall = 0; i_read_sel = 0; start_adr = '0; trap_adr = '0; jmp_adr = '0;
    mon_radr = '0;
    repeat (2) @(posedge clk);
    smp();
    chk("rst_pc_if", pc_if, 0);
    chk("rst_ram_radr", ram_radr, 0);
    chk("rst_inst", inst_id, NOP);
    chk("rst_pc_id", pc_id, 0);
    chk("rst_valid", valid_id, 0);
    chk("rst_count", q_count, 0);
    step(); rst_n = 1'b1;
    step(); smp();
    chk("idle_pc_if", pc_if, 0);

    // Start at 0x40
    step(); pc_start = 1; start_adr = 30'h40;
    step(); pc_start = 0; smp();
    chk("st_pc_if", pc_if, 32'h40);
    chk("st_radr", ram_radr, 32'h40);
    chk("st_valid1", valid_id, 0);
    step(); smp();
    chk("st_valid2", valid_id, 0);
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("st_pc_id", pc_id, 32'h40 + i);
      chk("st_inst", inst_id, word(32'h40 + i));
      chk("st_valid", valid_id, 1);
      chk("st_count", q_count, 1);
    end

    // ID back-pressure for 10 cycles
    step(); id_stall = 1;
    repeat (9) step();
    smp();
    chk("bp_count", q_count, 4);
    chk("bp_radr", ram_radr, 32'h47);
    chk("bp_pc_if", pc_if, 32'h47);
    chk("bp_head", pc_id, 32'h43);
    for (int i = 0; i < 8; i++) begin
      step(); if (i == 0) id_stall = 0; smp();
      chk("bp_drain_pc", pc_id, 32'h43 + i);
      chk("bp_drain_inst", inst_id, word(32'h43 + i));
      chk("bp_drain_valid", valid_id, 1);
    end

    // Jump with 3 entries queued
    step(); pc_start = 1; start_adr = 30'h80;
    step(); pc_start = 0;
    step();
    step(); id_stall = 1;
    step();
    step(); jmp_cond = 1; jmp_adr = 30'h100; smp();
    chk("jmp_pre_count", q_count, 3);
    chk("jmp_pre_head", pc_id, 32'h80);
    step(); jmp_cond = 0; id_stall = 0; smp();
    chk("jmp_valid", valid_id, 0);
    chk("jmp_count", q_count, 0);
    chk("jmp_inst", inst_id, NOP);
    chk("jmp_pc_id", pc_id, 0);
    chk("jmp_pc_if", pc_if, 32'h100);
    step(); smp();
    chk("jmp_valid2", valid_id, 0);
    step(); smp();
    chk("jmp_tgt_pc", pc_id, 32'h100);
    chk("jmp_tgt_valid", valid_id, 1);
    chk("jmp_tgt_inst", inst_id, word(32'h100));

    // Trap followed by a jump next cycle: jump ignored
    step(); trap_cond = 1; trap_adr = 30'h200;
    step(); trap_cond = 0; jmp_cond = 1; jmp_adr = 30'h300; smp();
    chk("trap_pc_if", pc_if, 32'h200);
    chk("trap_valid", valid_id, 0);
    step(); jmp_cond = 0; smp();
    chk("trap_pc_if2", pc_if, 32'h201);
    step(); smp();
    chk("trap_pc_id", pc_id, 32'h200);
    chk("trap_valid3", valid_id, 1);
    step(); smp();
    chk("trap_pc_id2", pc_id, 32'h201);

    // Trap and jump in the same cycle
    step(); trap_cond = 1; jmp_cond = 1; trap_adr = 30'h200; jmp_adr = 30'h300;
    step(); trap_cond = 0; jmp_cond = 0; smp();
    chk("tj_pc_if", pc_if, 32'h200);
    step(); step(); smp();
    chk("tj_pc_id", pc_id, 32'h200);

    // I-cache stall with two entries queued and one in flight
    step(); pc_start = 1; start_adr = 30'h500;
    step(); pc_start = 0;
    step();
    step(); id_stall = 1;
    step(); id_stall = 0; ic_stall = 1; smp();
    chk("ic_count", q_count, 2);
    chk("ic_head0", pc_id, 32'h500);
    step(); smp();
    chk("ic_head1", pc_id, 32'h501);
    step(); smp();
    chk("ic_head2", pc_id, 32'h502);
    step(); smp();
    chk("ic_empty_valid", valid_id, 0);
    chk("ic_empty_inst", inst_id, NOP);
    chk("ic_empty_pc", pc_id, 0);
    step(); smp();
    chk("ic_hold_pc_if", pc_if, 32'h503);
    step(); ic_stall = 0; smp();
    chk("ic_resume_radr", ram_radr, 32'h503);
    step();
    step(); smp();
    chk("ic_resume_pc_id", pc_id, 32'h503);
    chk("ic_resume_valid", valid_id, 1);

    // Monitor read
    step(); i_read_sel = 1; mon_radr = 14'h10; smp();
    chk("mon_radr", ram_radr, 32'h10);
    chk("mon_pc_if", pc_if, 32'h506);
    step(); i_read_sel = 0; smp();
    chk("mon_rdata", mon_rdata, word(32'h10));
    chk("mon_pc_if2", pc_if, 32'h506);
    step(); smp();
    chk("mon_pc_if3", pc_if, 32'h507);

    // Asynchronous reset mid-run, then stay halted
    step(); #2 rst_n = 1'b0; #1;
    chk("ar_valid", valid_id, 0);
    chk("ar_count", q_count, 0);
    chk("ar_pc_if", pc_if, 0);
    chk("ar_inst", inst_id, NOP);
    step(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); smp();
      chk("halt_pc_if", pc_if, 0);
      chk("halt_valid", valid_id, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
